// File: rtl/xbar_prog_verify.sv
// Program-and-verify engine for one crossbar row: drive, settle, sense, correct, per column.
// Optional per-column failure map enabled by defining XBAR_PV_FAIL_MAP_EN.
module xbar_prog_verify #(
   parameter int DATA_W     = 32,
   parameter int N          = 32,
   parameter int IDX_W      = 5,
   parameter int ITER_MAX   = 5,
   parameter int TOL        = 16,
   parameter int SETTLE_CYC = 4
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [IDX_W-1:0]  row_idx,
   input  logic              tgt_wr_en,
   input  logic [IDX_W-1:0]  tgt_wr_idx,
   input  logic [DATA_W-1:0] tgt_wr_data,
   output logic              busy,
   output logic              done,
   output logic [IDX_W:0]    fail_cnt,
   output logic [IDX_W-1:0]  mux_row,
   output logic [IDX_W-1:0]  mux_col,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_valid,
   output logic              adc_req,
   input  logic              adc_rdy,
   input  logic [DATA_W-1:0] adc_data
`ifdef XBAR_PV_FAIL_MAP_EN
   ,
   output logic [N-1:0]      fail_map
`endif
);

   localparam int ITER_W = $clog2(ITER_MAX + 1);
   localparam int SET_W  = $clog2(SETTLE_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PROGRAM, S_SETTLE, S_SENSE, S_COMPARE, S_DONE
   } state_t;

   state_t r_state, w_state_nxt;

   logic [DATA_W-1:0] r_tgt [N];
   logic [IDX_W-1:0]  r_row, r_col;
   logic [ITER_W-1:0] r_iter;
   logic [SET_W-1:0]  r_set_cnt;
   logic [DATA_W-1:0] r_drive, r_sensed;
   logic [IDX_W:0]    r_fail_cnt;
`ifdef XBAR_PV_FAIL_MAP_EN
   logic [N-1:0]      r_fail_map;
`endif

   logic                     w_wr, w_pass, w_iter_last, w_col_last;
   logic [IDX_W-1:0]         w_col_inc;
   logic [DATA_W-1:0]        w_tgt0, w_tgt_cur, w_tgt_nxt, w_drive_sat;
   logic signed [DATA_W:0]   w_err;
   logic [DATA_W:0]          w_abs_err;
   logic signed [DATA_W+1:0] w_drive_sum;

   // Target RAM is writable only while no row is in flight.
   assign w_wr = tgt_wr_en && (r_state == S_IDLE || r_state == S_DONE);

   always_ff @(posedge clk) begin
      if (w_wr) r_tgt[tgt_wr_idx] <= tgt_wr_data;
   end

   // Same-edge write to column 0 must be seen by the first drive.
   assign w_tgt0 = (w_wr && tgt_wr_idx == '0) ? tgt_wr_data : r_tgt[0];

   assign w_tgt_cur   = r_tgt[r_col];
   assign w_col_inc   = r_col + IDX_W'(1);
   assign w_tgt_nxt   = r_tgt[w_col_inc];
   assign w_col_last  = (r_col == IDX_W'(N - 1));
   assign w_iter_last = (r_iter == ITER_W'(ITER_MAX - 1));

   assign w_err       = $signed({1'b0, r_sensed}) - $signed({1'b0, w_tgt_cur});
   assign w_abs_err   = w_err[DATA_W] ? (DATA_W+1)'(-w_err) : (DATA_W+1)'(w_err);
   assign w_pass      = (w_abs_err <= (DATA_W+1)'(TOL));
   assign w_drive_sum = $signed({2'b00, r_drive}) - $signed({w_err[DATA_W], w_err});

   // Corrected drive clamps at both rails instead of wrapping.
   always_comb begin
      if (w_drive_sum[DATA_W+1])  w_drive_sat = '0;
      else if (w_drive_sum[DATA_W]) w_drive_sat = '1;
      else                        w_drive_sat = w_drive_sum[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      dac_valid   = 1'b0;
      adc_req     = 1'b0;
      case (r_state)
         S_IDLE:    if (start) w_state_nxt = S_PROGRAM;
         S_PROGRAM: begin
            busy        = 1'b1;
            dac_valid   = 1'b1;
            w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (r_set_cnt == SET_W'(SETTLE_CYC - 1)) w_state_nxt = S_SENSE;
         end
         S_SENSE: begin
            busy    = 1'b1;
            adc_req = 1'b1;
            if (adc_rdy) w_state_nxt = S_COMPARE;
         end
         S_COMPARE: begin
            busy = 1'b1;
            if ((w_pass || w_iter_last) && w_col_last) w_state_nxt = S_DONE;
            else                                       w_state_nxt = S_PROGRAM;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_row      <= '0;
         r_col      <= '0;
         r_iter     <= '0;
         r_set_cnt  <= '0;
         r_drive    <= '0;
         r_sensed   <= '0;
         r_fail_cnt <= '0;
`ifdef XBAR_PV_FAIL_MAP_EN
         r_fail_map <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_row      <= row_idx;
               r_col      <= '0;
               r_iter     <= '0;
               r_fail_cnt <= '0;
               r_drive    <= w_tgt0;
`ifdef XBAR_PV_FAIL_MAP_EN
               r_fail_map <= '0;
`endif
            end
            S_PROGRAM: r_set_cnt <= '0;
            S_SETTLE:  r_set_cnt <= r_set_cnt + SET_W'(1);
            S_SENSE:   if (adc_rdy) r_sensed <= adc_data;
            S_COMPARE: begin
               if (w_pass || w_iter_last) begin
                  if (!w_pass) begin
                     r_fail_cnt <= r_fail_cnt + (IDX_W+1)'(1);
`ifdef XBAR_PV_FAIL_MAP_EN
                     r_fail_map[r_col] <= 1'b1;
`endif
                  end
                  if (!w_col_last) begin
                     r_col   <= w_col_inc;
                     r_iter  <= '0;
                     r_drive <= w_tgt_nxt;
                  end
               end else begin
                  r_drive <= w_drive_sat;
                  r_iter  <= r_iter + ITER_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign mux_row  = r_row;
   assign mux_col  = r_col;
   assign dac_data = r_drive;
   assign fail_cnt = r_fail_cnt;
`ifdef XBAR_PV_FAIL_MAP_EN
   assign fail_map = r_fail_map;
`endif

endmodule

// File: tb/tb_xbar_prog_verify.sv
// Directed self-checking bench for xbar_prog_verify with a behavioural ADC responder.
module tb_xbar_prog_verify;
   localparam int DATA_W = 32;
   localparam int N      = 32;
   localparam int IDX_W  = 5;

   logic              clk = 1'b0, rstn = 1'b0, start = 1'b0;
   logic [IDX_W-1:0]  row_idx = '0, tgt_wr_idx = '0;
   logic              tgt_wr_en = 1'b0;
   logic [DATA_W-1:0] tgt_wr_data = '0;
   logic              busy, done, dac_valid, adc_req;
   logic              adc_rdy = 1'b0;
   logic [DATA_W-1:0] adc_data = '0, dac_data;
   logic [IDX_W:0]    fail_cnt;
   logic [IDX_W-1:0]  mux_row, mux_col;
`ifdef XBAR_PV_FAIL_MAP_EN
   logic [N-1:0]      fail_map;
`endif

   xbar_prog_verify #(.DATA_W(DATA_W), .N(N), .IDX_W(IDX_W), .ITER_MAX(5), .TOL(16), .SETTLE_CYC(4)) dut (
      .clk(clk), .rstn(rstn), .start(start), .row_idx(row_idx),
      .tgt_wr_en(tgt_wr_en), .tgt_wr_idx(tgt_wr_idx), .tgt_wr_data(tgt_wr_data),
      .busy(busy), .done(done), .fail_cnt(fail_cnt), .mux_row(mux_row), .mux_col(mux_col),
      .dac_data(dac_data), .dac_valid(dac_valid), .adc_req(adc_req),
      .adc_rdy(adc_rdy), .adc_data(adc_data)
`ifdef XBAR_PV_FAIL_MAP_EN
      , .fail_map(fail_map)
`endif
   );

   int checks = 0, errors = 0;
   int cyc = 0, s_cyc = 0;
   int pulses, done_cnt, done_cyc, first_col, req_run, req_max, req_min;
   int col_pulses [N];
   logic [DATA_W-1:0] drv [N][8];
   int adc_kind [N];
   int rdy_delay = 0, req_cnt = 0;
   logic busy_at_start, timed_out;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ADC reply per column: 0 echo, 1 +40, 2 zero, 3 full-scale, 4 +16, 5 -17
   function automatic logic [DATA_W-1:0] adc_resp(input int k, input logic [DATA_W-1:0] d);
      case (k)
         1: return d + 32'd40;
         2: return '0;
         3: return '1;
         4: return d + 32'd16;
         5: return d - 32'd17;
         default: return d;
      endcase
   endfunction

   always @(negedge clk) begin
      if (dac_valid) begin
         if (pulses == 0) first_col = int'(mux_col);
         pulses++;
         if (col_pulses[mux_col] < 8) drv[mux_col][col_pulses[mux_col]] = dac_data;
         col_pulses[mux_col]++;
      end
      if (adc_req) req_run++;
      else if (req_run > 0) begin
         if (req_run > req_max) req_max = req_run;
         if (req_run < req_min) req_min = req_run;
         req_run = 0;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (adc_req) begin
         if (req_cnt >= rdy_delay) begin adc_rdy = 1'b1; adc_data = adc_resp(adc_kind[mux_col], dac_data); end
         else adc_rdy = 1'b0;
         req_cnt++;
      end else begin
         adc_rdy = 1'b0;
         req_cnt = 0;
      end
   end

   task automatic clear_mon();
      pulses = 0; done_cnt = 0; done_cyc = -1; first_col = -1;
      req_run = 0; req_max = 0; req_min = 1000;
      for (int i = 0; i < N; i++) col_pulses[i] = 0;
   endtask

   task automatic write_tgt(input int idx, input logic [DATA_W-1:0] d);
      @(negedge clk); #1;
      tgt_wr_en = 1'b1; tgt_wr_idx = IDX_W'(idx); tgt_wr_data = d;
      @(negedge clk); #1;
      tgt_wr_en = 1'b0;
   endtask

   task automatic start_row(input int r, input logic wr0, input logic [DATA_W-1:0] d0);
      @(negedge clk); #1;
      clear_mon();
      start = 1'b1; row_idx = IDX_W'(r);
      if (wr0) begin tgt_wr_en = 1'b1; tgt_wr_idx = '0; tgt_wr_data = d0; end
      s_cyc = cyc + 1;
      @(negedge clk); #1;
      start = 1'b0; tgt_wr_en = 1'b0;
      busy_at_start = busy;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin @(negedge clk); #1; n++; end
      timed_out = (done_cnt == 0);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if ({busy, done, dac_valid, adc_req} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, dac_valid, adc_req}); end
      checks++; if (dac_data !== '0) begin errors++; $display("FAIL reset_dac: got %0h expected 0", dac_data); end
      checks++; if ({mux_row, mux_col, fail_cnt} !== '0) begin errors++; $display("FAIL reset_mux_cnt: got %0h expected 0", {mux_row, mux_col, fail_cnt}); end
`ifdef XBAR_PV_FAIL_MAP_EN
      checks++; if (fail_map !== '0) begin errors++; $display("FAIL reset_map: got %0h expected 0", fail_map); end
`endif
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_all_pass();
      for (int i = 0; i < N; i++) begin adc_kind[i] = 0; write_tgt(i, 32'd1000); end
      rdy_delay = 0;
      start_row(3, 1'b0, '0);
      wait_done(400);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL all_timeout: done not seen, got %b expected 0", timed_out); end
      checks++; if (busy_at_start !== 1'b1) begin errors++; $display("FAIL all_busy: got %b expected 1", busy_at_start); end
      checks++; if (pulses != 32) begin errors++; $display("FAIL all_pulses: got %0d expected 32", pulses); end
      checks++; if (done_cyc - s_cyc != 224) begin errors++; $display("FAIL all_latency: got %0d expected 224", done_cyc - s_cyc); end
      checks++; if (mux_row !== 5'd3) begin errors++; $display("FAIL all_row: got %0d expected 3", mux_row); end
      checks++; if (first_col != 0) begin errors++; $display("FAIL all_first_col: got %0d expected 0", first_col); end
      checks++; if (fail_cnt !== '0) begin errors++; $display("FAIL all_fail_cnt: got %0d expected 0", fail_cnt); end
      checks++; if (drv[31][0] !== 32'd1000) begin errors++; $display("FAIL all_drive31: got %0d expected 1000", drv[31][0]); end
      @(negedge clk); #1;
      checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL all_done_pulse: got %b expected 00", {done, busy}); end
   endtask

   task automatic test_converge();
      adc_kind[5] = 1;
      start_row(1, 1'b0, '0);
      wait_done(400);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL conv_timeout: got %b expected 0", timed_out); end
      checks++; if (col_pulses[5] != 2) begin errors++; $display("FAIL conv_col5_pulses: got %0d expected 2", col_pulses[5]); end
      checks++; if (drv[5][0] !== 32'd1000) begin errors++; $display("FAIL conv_drive0: got %0d expected 1000", drv[5][0]); end
      checks++; if (drv[5][1] !== 32'd960) begin errors++; $display("FAIL conv_drive1: got %0d expected 960", drv[5][1]); end
      checks++; if (done_cyc - s_cyc != 231) begin errors++; $display("FAIL conv_latency: got %0d expected 231", done_cyc - s_cyc); end
      checks++; if (fail_cnt !== '0) begin errors++; $display("FAIL conv_fail_cnt: got %0d expected 0", fail_cnt); end
   endtask

   task automatic test_fail_iter();
      logic [DATA_W-1:0] exp_d;
      adc_kind[5] = 0; adc_kind[7] = 2;
      write_tgt(7, 32'd500);
      start_row(2, 1'b0, '0);
      wait_done(400);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL fail_timeout: got %b expected 0", timed_out); end
      checks++; if (col_pulses[7] != 5) begin errors++; $display("FAIL fail_col7_pulses: got %0d expected 5", col_pulses[7]); end
      for (int k = 0; k < 5; k++) begin
         exp_d = 32'(500 * (k + 1));
         checks++; if (drv[7][k] !== exp_d) begin errors++; $display("FAIL fail_drive%0d: got %0d expected %0d", k, drv[7][k], exp_d); end
      end
      checks++; if (done_cyc - s_cyc != 252) begin errors++; $display("FAIL fail_latency: got %0d expected 252", done_cyc - s_cyc); end
      repeat (5) @(negedge clk);
      #1;
      checks++; if (fail_cnt !== 6'd1) begin errors++; $display("FAIL fail_cnt_hold: got %0d expected 1", fail_cnt); end
`ifdef XBAR_PV_FAIL_MAP_EN
      checks++; if (fail_map !== 32'h80) begin errors++; $display("FAIL fail_map: got %0h expected 80", fail_map); end
`endif
   endtask

   task automatic test_boundaries();
      adc_kind[7] = 0; write_tgt(7, 32'd1000);
      adc_kind[9] = 2; write_tgt(9, 32'hFFFF_FFF0);
      adc_kind[11] = 3; write_tgt(11, 32'd100);
      adc_kind[12] = 4;
      adc_kind[13] = 5;
      start_row(0, 1'b0, '0);
      wait_done(600);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bnd_timeout: got %b expected 0", timed_out); end
      checks++; if (drv[9][1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bnd_sat_hi1: got %0h expected ffffffff", drv[9][1]); end
      checks++; if (drv[9][4] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bnd_sat_hi4: got %0h expected ffffffff", drv[9][4]); end
      checks++; if (drv[11][1] !== 32'd0) begin errors++; $display("FAIL bnd_sat_lo1: got %0h expected 0", drv[11][1]); end
      checks++; if (drv[11][4] !== 32'd0) begin errors++; $display("FAIL bnd_sat_lo4: got %0h expected 0", drv[11][4]); end
      checks++; if (col_pulses[12] != 1) begin errors++; $display("FAIL bnd_tol16: got %0d pulses expected 1", col_pulses[12]); end
      checks++; if (col_pulses[13] != 2) begin errors++; $display("FAIL bnd_tol17: got %0d pulses expected 2", col_pulses[13]); end
      checks++; if (drv[13][1] !== 32'd1017) begin errors++; $display("FAIL bnd_tol17_drive: got %0d expected 1017", drv[13][1]); end
      checks++; if (pulses != 41) begin errors++; $display("FAIL bnd_pulses: got %0d expected 41", pulses); end
      checks++; if (fail_cnt !== 6'd2) begin errors++; $display("FAIL bnd_fail_cnt: got %0d expected 2", fail_cnt); end
`ifdef XBAR_PV_FAIL_MAP_EN
      checks++; if (fail_map !== 32'hA00) begin errors++; $display("FAIL bnd_fail_map: got %0h expected a00", fail_map); end
`endif
   endtask

   task automatic test_rdy_delay_ignore();
      adc_kind[9] = 0; adc_kind[11] = 0; adc_kind[12] = 0; adc_kind[13] = 0;
      write_tgt(9, 32'd1000); write_tgt(11, 32'd1000);
      rdy_delay = 3;
      start_row(6, 1'b0, '0);
      repeat (50) @(negedge clk);
      #1;
      start = 1'b1; row_idx = 5'd2; tgt_wr_en = 1'b1; tgt_wr_idx = 5'd31; tgt_wr_data = 32'd5;
      @(negedge clk); #1;
      start = 1'b0; tgt_wr_en = 1'b0;
      wait_done(600);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL dly_timeout: got %b expected 0", timed_out); end
      checks++; if (req_max != 4 || req_min != 4) begin errors++; $display("FAIL dly_req_len: got %0d..%0d expected 4..4", req_min, req_max); end
      checks++; if (done_cyc - s_cyc != 320) begin errors++; $display("FAIL dly_latency: got %0d expected 320", done_cyc - s_cyc); end
      checks++; if (mux_row !== 5'd6) begin errors++; $display("FAIL busy_start_row: got %0d expected 6", mux_row); end
      checks++; if (drv[31][0] !== 32'd1000) begin errors++; $display("FAIL busy_write: got %0d expected 1000", drv[31][0]); end
      checks++; if (pulses != 32) begin errors++; $display("FAIL dly_pulses: got %0d expected 32", pulses); end
      checks++; if (fail_cnt !== '0) begin errors++; $display("FAIL dly_fail_cnt_cleared: got %0d expected 0", fail_cnt); end
      repeat (10) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid_row();
      int n;
      rdy_delay = 0;
      adc_kind[3] = 2;
      start_row(4, 1'b0, '0);
      n = 0;
      while (col_pulses[10] == 0 && n < 400) begin @(negedge clk); #1; n++; end
      checks++; if (col_pulses[10] == 0) begin errors++; $display("FAIL rst_col10_timeout: got 0 pulses expected 1"); end
      @(negedge clk); #1;
      checks++; if ({busy, dac_valid, mux_col} !== {2'b10, 5'd10}) begin errors++; $display("FAIL rst_in_settle: got %b/%b/%0d expected 1/0/10", busy, dac_valid, mux_col); end
      rstn = 1'b0;
      #1;
      checks++; if ({busy, done, dac_valid, adc_req} !== 4'b0) begin errors++; $display("FAIL rst_async_ctrl: got %b expected 0000", {busy, done, dac_valid, adc_req}); end
      checks++; if ({dac_data, mux_row, mux_col, fail_cnt} !== '0) begin errors++; $display("FAIL rst_async_data: got %0h expected 0", {dac_data, mux_row, mux_col, fail_cnt}); end
`ifdef XBAR_PV_FAIL_MAP_EN
      checks++; if (fail_map !== '0) begin errors++; $display("FAIL rst_async_map: got %0h expected 0", fail_map); end
`endif
      repeat (2) @(negedge clk);
      #1;
      rstn = 1'b1;
      adc_kind[3] = 0;
      start_row(8, 1'b1, 32'd1234);
      wait_done(400);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rerun_timeout: got %b expected 0", timed_out); end
      checks++; if (first_col != 0) begin errors++; $display("FAIL rerun_first_col: got %0d expected 0", first_col); end
      checks++; if (drv[0][0] !== 32'd1234) begin errors++; $display("FAIL same_edge_write: got %0d expected 1234", drv[0][0]); end
      checks++; if (done_cyc - s_cyc != 224) begin errors++; $display("FAIL rerun_latency: got %0d expected 224", done_cyc - s_cyc); end
      checks++; if (fail_cnt !== '0 || mux_row !== 5'd8) begin errors++; $display("FAIL rerun_state: got cnt %0d row %0d expected 0/8", fail_cnt, mux_row); end
   endtask

   initial begin
      for (int i = 0; i < N; i++) adc_kind[i] = 0;
      clear_mon();
      test_reset();
      test_all_pass();
      test_converge();
      test_fail_iter();
      test_boundaries();
      test_rdy_delay_ignore();
      test_reset_mid_row();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
